rsh_64bit_seq: RTL and testbench

//   Multi-cycle 64-bit right shifter for the eBPF core ALU. Serves BPF_RSH (logical) and BPF_ARSH (arithmetic).

---
 rtl/rsh_64bit_seq.sv | 185 ++++++++++++++++++
 tb/tb_rsh_64bit_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rsh_64bit_seq.sv
// ============================================================================
// Module   : rsh_64bit_seq
// Purpose  : Multi-cycle 64-bit right shifter (logical / arithmetic) for the
//            eBPF ALU. Resolves the barrel stages 32,16,8,4,2,1 in groups of
//            STAGES_PER_CYCLE per SHIFT cycle, with valid/ready handshakes on
//            both the operand and the result side.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - operand handshake (ready only in IDLE)
//            a, b            - value to shift, shift amount (low 6 bits used)
//            arith           - 1 = sign fill, 0 = zero fill
//            alu32           - 32-bit op (only when RSH_ALU32_EN is defined)
//            out_valid/ready - result handshake
//            c               - shifted result, stable while out_valid is high
//            busy            - high in SHIFT or DONE
// Config   : RSH_ALU32_EN - adds the alu32 port and 32-bit operation mode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsh_64bit_seq #(
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        arith,
`ifdef RSH_ALU32_EN
  input  logic        alu32,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] c,
  output logic        busy
);

  localparam int         N_CYC      = 6 / STAGES_PER_CYCLE;
  localparam logic [2:0] c_PTR_STEP = 3'(STAGES_PER_CYCLE);
  // Stage pointer value during the final SHIFT cycle (it covers stage 0).
  localparam logic [2:0] c_LAST_PTR = 3'(STAGES_PER_CYCLE - 1);

  generate
    if (!(STAGES_PER_CYCLE == 1 || STAGES_PER_CYCLE == 2 ||
          STAGES_PER_CYCLE == 3 || STAGES_PER_CYCLE == 6)) begin : g_bad_spc
      $error("rsh_64bit_seq: STAGES_PER_CYCLE must be 1, 2, 3 or 6");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_opnd;
  logic [5:0]  r_shamt;
  logic        r_fill;
  logic [2:0]  r_ptr;
  logic [63:0] r_c;
`ifdef RSH_ALU32_EN
  logic        r_alu32;
`endif

  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_shamt8;
  logic [63:0] w_stage [0:STAGES_PER_CYCLE];
  logic [63:0] w_result;
  logic        w_unused_b;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_last     = (r_ptr == c_LAST_PTR);
  // Padded so the per-stage index (3 bits) always lands inside the vector.
  assign w_shamt8   = {2'b00, r_shamt};
  assign w_unused_b = ^b[63:6];

  // One cycle's worth of barrel stages, highest stage first.
  assign w_stage[0] = r_opnd;
  for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_stage
    logic [2:0] w_k;
    logic [6:0] w_amt;
    logic [63:0] w_fill_mask;
    assign w_k         = r_ptr - 3'(j);
    assign w_amt       = 7'd1 << w_k;
    assign w_fill_mask = r_fill ? ~({64{1'b1}} >> w_amt) : 64'd0;
    assign w_stage[j+1] = w_shamt8[w_k] ? ((w_stage[j] >> w_amt) | w_fill_mask)
                                        : w_stage[j];
  end

`ifdef RSH_ALU32_EN
  assign w_result = r_alu32 ? {32'd0, w_stage[STAGES_PER_CYCLE][31:0]}
                            : w_stage[STAGES_PER_CYCLE];
`else
  assign w_result = w_stage[STAGES_PER_CYCLE];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opnd  <= 64'd0;
      r_shamt <= 6'd0;
      r_fill  <= 1'b0;
      r_ptr   <= 3'd0;
      r_c     <= 64'd0;
`ifdef RSH_ALU32_EN
      r_alu32 <= 1'b0;
`endif
    end else if (w_accept) begin
      r_ptr <= 3'd5;
`ifdef RSH_ALU32_EN
      r_alu32 <= alu32;
      if (alu32) begin
        r_opnd  <= arith ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
        r_shamt <= {1'b0, b[4:0]};
        r_fill  <= arith & a[31];
      end else begin
        r_opnd  <= a;
        r_shamt <= b[5:0];
        r_fill  <= arith & a[63];
      end
`else
      r_opnd  <= a;
      r_shamt <= b[5:0];
      r_fill  <= arith & a[63];
`endif
    end else if (r_state == S_SHIFT) begin
      r_opnd <= w_stage[STAGES_PER_CYCLE];
      r_ptr  <= r_ptr - c_PTR_STEP;
      // c only moves on the SHIFT->DONE edge so it stays put until the next result.
      if (w_last) begin
        r_c <= w_result;
      end
    end
  end

  assign c = r_c;

endmodule

`default_nettype wire

// File: tb/tb_rsh_64bit_seq.sv
// ============================================================================
// Module   : tb_rsh_64bit_seq
// Purpose  : Self-checking bench for rsh_64bit_seq. Four instances cover
//            STAGES_PER_CYCLE = 1, 2, 3, 6; each is exercised in turn with
//            directed and random operations against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsh_64bit_seq;

  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] iv, ir, ov, ordy, bsy, ar, a32;
  logic [63:0]   av [NI];
  logic [63:0]   bv [NI];
  logic [63:0]   cv [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rsh_64bit_seq #(
      .STAGES_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : 6)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (av[g]),
      .b        (bv[g]),
      .arith    (ar[g]),
`ifdef RSH_ALU32_EN
      .alu32    (a32[g]),
`endif
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .c        (cv[g]),
      .busy     (bsy[g])
    );
  end

  function automatic int ncyc(input int idx);
    case (idx)
      0:       return 6;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: plain shift operators on the architecturally visible operands.
  function automatic logic [63:0] ref_rsh(input logic [63:0] x, input logic [63:0] amt,
                                          input logic ari, input logic w32);
    int sh;
    logic signed [31:0] lo;
    logic signed [63:0] full;
    if (w32) begin
      sh = int'(amt % 64'd32);
      lo = x[31:0];
      return {32'd0, ari ? 32'(lo >>> sh) : 32'(x[31:0] >> sh)};
    end
    sh   = int'(amt % 64'd64);
    full = x;
    return ari ? 64'(full >>> sh) : (x >> sh);
  endfunction

  task automatic chk(input string tag, input int idx, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic issue(input int idx, input logic [63:0] x, input logic [63:0] amt,
                       input logic ari, input logic w32);
    av[idx] = x; bv[idx] = amt; ar[idx] = ari; a32[idx] = w32; iv[idx] = 1'b1;
    chk("in_ready_idle", idx, 64'(ir[idx]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv[idx] = 1'b0;
    chk("busy_shift", idx, 64'(bsy[idx]), 64'd1);
    chk("in_ready_shift", idx, 64'(ir[idx]), 64'd0);
  endtask

  task automatic wait_result(input int idx, input logic [63:0] exp);
    int lat;
    lat = 1;
    while (ov[idx] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", idx, 64'(lat), 64'(ncyc(idx) + 1));
    chk("result", idx, cv[idx], exp);
  endtask

  task automatic release_result(input int idx, input logic [63:0] exp);
    ordy[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[idx] = 1'b0;
    chk("out_valid_after_xfer", idx, 64'(ov[idx]), 64'd0);
    chk("in_ready_after_xfer", idx, 64'(ir[idx]), 64'd1);
    chk("c_persists", idx, cv[idx], exp);
  endtask

  task automatic run(input int idx, input logic [63:0] x, input logic [63:0] amt,
                     input logic ari, input logic w32, input logic [63:0] exp);
    issue(idx, x, amt, ari, w32);
    wait_result(idx, exp);
    release_result(idx, exp);
  endtask

  initial begin
    logic [63:0] ra, rb, e1, e2;
    logic        rar, r32;
    rst = 1'b1; iv = '0; ordy = '0; ar = '0; a32 = '0;
    for (int i = 0; i < NI; i++) begin
      av[i] = 64'd0; bv[i] = 64'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", i, 64'(ir[i]), 64'd1);
      chk("rst_out_valid", i, 64'(ov[i]), 64'd0);
      chk("rst_busy", i, 64'(bsy[i]), 64'd0);
      chk("rst_c", i, cv[i], 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      run(i, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 1'b0, 64'h0800_0000_0000_0000);
      run(i, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 1'b0, 64'hF800_0000_0000_0000);
      run(i, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      run(i, 64'h0123_4567_89AB_CDEF, 64'd67, 1'b0, 1'b0, 64'h0024_68AC_F135_79BD);
      run(i, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);

      // Back-pressure in DONE with a competing operand held on the input.
      e1 = ref_rsh(64'hC3C3_0000_FFFF_1234, 64'd9, 1'b1, 1'b0);
      e2 = ref_rsh(64'h7777_6666_5555_4444, 64'd17, 1'b0, 1'b0);
      issue(i, 64'hC3C3_0000_FFFF_1234, 64'd9, 1'b1, 1'b0);
      wait_result(i, e1);
      av[i] = 64'h7777_6666_5555_4444; bv[i] = 64'd17; ar[i] = 1'b0; iv[i] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_out_valid", i, 64'(ov[i]), 64'd1);
        chk("hold_in_ready", i, 64'(ir[i]), 64'd0);
        chk("hold_c", i, cv[i], e1);
      end
      ordy[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[i] = 1'b0;
      chk("hold_release_idle", i, 64'(ir[i]), 64'd1);
      chk("hold_release_ov", i, 64'(ov[i]), 64'd0);
      @(posedge clk);
      @(negedge clk);
      iv[i] = 1'b0;
      chk("hold_next_busy", i, 64'(bsy[i]), 64'd1);
      wait_result(i, e2);
      release_result(i, e2);

      // Reset during the second SHIFT cycle (DONE for the single-cycle build).
      issue(i, 64'hDEAD_BEEF_0BAD_F00D, 64'd13, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", i, 64'(ov[i]), 64'd0);
      chk("abort_c", i, cv[i], 64'd0);
      chk("abort_in_ready", i, 64'(ir[i]), 64'd1);
      chk("abort_busy", i, 64'(bsy[i]), 64'd0);
      run(i, 64'hDEAD_BEEF_0BAD_F00D, 64'd13, 1'b1, 1'b0,
          ref_rsh(64'hDEAD_BEEF_0BAD_F00D, 64'd13, 1'b1, 1'b0));

`ifdef RSH_ALU32_EN
      run(i, 64'hFFFF_FFFF_8000_0000, 64'd36, 1'b1, 1'b1, 64'h0000_0000_F800_0000);
      run(i, 64'hFFFF_FFFF_8000_0000, 64'd36, 1'b0, 1'b1, 64'h0000_0000_0800_0000);
`endif

      for (int n = 0; n < 16; n++) begin
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        rar = 1'($urandom);
`ifdef RSH_ALU32_EN
        r32 = 1'($urandom);
`else
        r32 = 1'b0;
`endif
        run(i, ra, rb, rar, r32, ref_rsh(ra, rb, rar, r32));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
